fu_operand_join: RTL

Upstream operand stage for `functional_unit`. It accepts two independent valid/ready operand streams and buffers each in its own small FIFO. When both sides hold data, it presents one aligned operand pair on `dout_1`/`dout_2` with a single `dout_v`, which connects directly to the FU's `din_1`/`din_2`/`din_v`/`din_r`. Each pair is consumed atomically, so the FU always sees matched operands even when the streams arrive skewed.

---
 rtl/fu_operand_join.sv | 110 +++++++++++
 1 files changed

// File: rtl/fu_operand_join.sv
// Operand join for functional_unit: two skew-tolerant FIFOs, one aligned pair out.
// Optional FU_JOIN_CONST_EN replaces operand 2 with const_value.
module fu_operand_join #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic                  in1_v,
    output logic                  in1_r,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic                  in2_v,
    output logic                  in2_r,
    output logic [DATA_WIDTH-1:0] dout_1,
    output logic [DATA_WIDTH-1:0] dout_2,
    output logic                  dout_v,
    input  logic                  dout_r,
    input  logic                  clear
`ifdef FU_JOIN_CONST_EN
    ,
    input  logic                  const_en,
    input  logic [DATA_WIDTH-1:0] const_value
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem1 [DEPTH];
    logic [DATA_WIDTH-1:0] mem2 [DEPTH];
    logic [AW-1:0]         wr1, rd1, wr2, rd2;
    logic [CW-1:0]         cnt1, cnt2;

    logic const_mode;
    logic push1, push2, pop, pop2;

`ifdef FU_JOIN_CONST_EN
    assign const_mode = const_en;
    assign dout_2     = const_mode ? const_value : mem2[rd2];
`else
    assign const_mode = 1'b0;
    assign dout_2     = mem2[rd2];
`endif

    // Ready depends only on registered occupancy, never on dout_r.
    assign in1_r  = (cnt1 != FULL);
    assign in2_r  = !const_mode && (cnt2 != FULL);
    assign dout_v = (cnt1 != '0) && (const_mode || (cnt2 != '0));
    assign dout_1 = mem1[rd1];

    assign push1 = in1_v && in1_r;
    assign push2 = in2_v && in2_r;
    assign pop   = dout_v && dout_r;
    assign pop2  = pop && !const_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr1  <= '0;
            rd1  <= '0;
            cnt1 <= '0;
            mem1 <= '{default: '0};
        end else if (clear) begin
            wr1  <= '0;
            rd1  <= '0;
            cnt1 <= '0;
        end else begin
            if (push1) begin
                mem1[wr1] <= in1;
                wr1       <= wr1 + AW'(1);
            end
            if (pop) begin
                rd1 <= rd1 + AW'(1);
            end
            unique case ({push1, pop})
                2'b10:   cnt1 <= cnt1 + CW'(1);
                2'b01:   cnt1 <= cnt1 - CW'(1);
                default: cnt1 <= cnt1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr2  <= '0;
            rd2  <= '0;
            cnt2 <= '0;
            mem2 <= '{default: '0};
        end else if (clear) begin
            wr2  <= '0;
            rd2  <= '0;
            cnt2 <= '0;
        end else begin
            if (push2) begin
                mem2[wr2] <= in2;
                wr2       <= wr2 + AW'(1);
            end
            if (pop2) begin
                rd2 <= rd2 + AW'(1);
            end
            unique case ({push2, pop2})
                2'b10:   cnt2 <= cnt2 + CW'(1);
                2'b01:   cnt2 <= cnt2 - CW'(1);
                default: cnt2 <= cnt2;
            endcase
        end
    end

endmodule
